// File: rtl/alu_mul_seq_pkg.sv
// Shared types for the shift-and-add multiply sequencer.
// State encoding and ALU one-hot select bundle.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_e;

   typedef struct packed {
      logic add;
      logic sub;
      logic nop;
      logic pass1;
      logic pass2;
   } alu_sel_t;

   localparam alu_sel_t ALU_SEL_NOP   = alu_sel_t'(5'b00100);
   localparam alu_sel_t ALU_SEL_ADD   = alu_sel_t'(5'b10000);
   localparam alu_sel_t ALU_SEL_PASS1 = alu_sel_t'(5'b00010);

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand and product valid/ready handshakes.
// The core side is master, the sequencer is slave.
interface alu_mul_seq_if #(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle MUL sequencer that borrows the shared ALU.
// Shift-and-add with early exit once the multiplier runs out.
module alu_mul_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   alu_mul_seq_if.slave     bus,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_sel_add,
   output logic             alu_sel_sub,
   output logic             alu_sel_nop,
   output logic             alu_sel_pass1,
   output logic             alu_sel_pass2,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   mul_state_e       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   alu_sel_t         sel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   // FSM and datapath: one partial product per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc    <= '0;
                  mcand  <= bus.in_a;
                  mplier <= bus.in_b;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= alu_result;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CNT_LAST || (mplier >> 1) == '0)
                  state <= DONE;
            end
            DONE: begin
               if (bus.out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ALU drive decoded from registered state only
   always_comb begin
      sel  = ALU_SEL_NOP;
      op_a = '0;
      op_b = '0;
      if (state == RUN) begin
         op_a = acc;
         op_b = mcand;
         sel  = mplier[0] ? ALU_SEL_ADD : ALU_SEL_PASS1;
      end
   end

   assign alu_a         = op_a;
   assign alu_b         = op_b;
   assign alu_sel_add   = sel.add;
   assign alu_sel_sub   = sel.sub;
   assign alu_sel_nop   = sel.nop;
   assign alu_sel_pass1 = sel.pass1;
   assign alu_sel_pass2 = sel.pass2;

   assign busy           = (state == RUN);
   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.out_result = acc;

endmodule
